spi_frame_rx: RTL and testbench

SPI_FRAME_RX -- requirements
Module: spi_frame_rx

---
 rtl/smu_spi_pkg.sv | 15 +
 rtl/sync_ff.sv | 49 ++++
 rtl/spi_frame_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_frame_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/smu_spi_pkg.sv
// Shared constants and types for the SPI frame receiver.
package smu_spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_BITS  = 8;
    localparam int unsigned ERR_CNT_W  = 8;

    // IDLE: CS high; SHIFT: receiving up to FRAME_BITS; OVERRUN: too many bits seen.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StShift   = 2'd1,
        StOverrun = 2'd2
    } state_e;

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchronizer with an optional third flop for edge detection.
module sync_ff #(
    parameter logic RESET_VAL = 1'b0,
    parameter bit   EDGE_DET  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;

    // Two-stage synchronizer for the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

    if (EDGE_DET) begin : g_edge
        logic prev_q;

        // Delayed copy of the synchronized level for edge detection.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= RESET_VAL;
            end else begin
                prev_q <= sync_q;
            end
        end

        assign rise = sync_q & ~prev_q;
        assign fall = ~sync_q & prev_q;
    end else begin : g_no_edge
        assign rise = 1'b0;
        assign fall = 1'b0;
    end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: oversampled SPI, address-triggered read, frame checking.
module spi_frame_rx #(
    parameter int unsigned FRAME_BITS = smu_spi_pkg::FRAME_BITS,
    parameter int unsigned ADDR_BITS  = smu_spi_pkg::ADDR_BITS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                spi_clk,
    input  logic                                spi_cs,
    input  logic                                spi_mosi,
    output logic                                spi_miso,
    output logic                                rd_req,
    output logic [ADDR_BITS-1:0]                rd_addr,
    input  logic [FRAME_BITS-ADDR_BITS-1:0]     rd_data,
    output logic                                frame_valid,
    output logic [FRAME_BITS-1:0]               frame_data,
    output logic                                frame_err,
    output logic [smu_spi_pkg::ERR_CNT_W-1:0]   err_cnt
);

    import smu_spi_pkg::*;

    localparam int unsigned DATA_BITS = FRAME_BITS - ADDR_BITS;
    localparam int unsigned CNT_W     = $clog2(FRAME_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_BITS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

    // Synchronized SPI inputs and their edges.
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall_raw;
    logic mosi_s, mosi_rise, mosi_fall;

    sync_ff #(
        .RESET_VAL (1'b0),
        .EDGE_DET  (1'b1)
    ) u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_clk),
        .q     (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_ff #(
        .RESET_VAL (1'b1),
        .EDGE_DET  (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_cs),
        .q     (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall_raw)
    );

    sync_ff #(
        .RESET_VAL (1'b0),
        .EDGE_DET  (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_mosi),
        .q     (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    // State and datapath registers.
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]   tx_q, tx_d;
    logic                   tx_armed_q, tx_armed_d;
    logic                   miso_q, miso_d;
    logic                   rd_req_q, rd_req_d;
    logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [FRAME_BITS-1:0]  frame_data_q, frame_data_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [1:0]             holdoff_q, holdoff_d;

    // The CS synchronizer resets high; if CS is already low when reset lifts, the flush
    // looks like a falling edge. Ignore CS falls until the synchronizer has settled so a
    // frame interrupted by reset is never picked up halfway.
    logic cs_fall;
    assign cs_fall   = cs_fall_raw && (holdoff_q == 2'd0);
    assign holdoff_d = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : holdoff_q;

    // A CS rising edge wins over any coincident spi_clk edge.
    logic sample, tx_edge;
    assign sample  = sclk_fall && !cs_rise;
    assign tx_edge = sclk_rise && !cs_rise;

    // Next-state logic for the frame FSM and all datapath registers.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        tx_armed_d    = tx_armed_q;
        miso_d        = miso_q;
        rd_req_d      = 1'b0;
        rd_addr_d     = rd_addr_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_data_d  = frame_data_q;
        err_cnt_d     = err_cnt_q;

        // Read data arrives the cycle after the request.
        if (rd_req_q) begin
            tx_d       = rd_data;
            tx_armed_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                miso_d     = 1'b0;
                tx_armed_d = 1'b0;
                if (cs_fall) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            StShift, StOverrun: begin
                if (cs_rise) begin
                    state_d    = StIdle;
                    miso_d     = 1'b0;
                    tx_armed_d = 1'b0;
                    if (state_q == StShift && bit_cnt_q == CNT_FULL) begin
                        frame_valid_d = 1'b1;
                        frame_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end else begin
                    if (sample) begin
                        shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
                        if (bit_cnt_q != CNT_SAT) begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                        if (state_q == StShift && bit_cnt_q == CNT_ADDR_LAST) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = {shift_q[ADDR_BITS-2:0], mosi_s};
                        end
                        if (bit_cnt_q >= CNT_FULL) begin
                            state_d    = StOverrun;
                            miso_d     = 1'b0;
                            tx_armed_d = 1'b0;
                        end
                    end
                    if (tx_edge && state_q == StShift && tx_armed_q) begin
                        miso_d = tx_q[DATA_BITS-1];
                        tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
                    end
                    if (state_q == StOverrun) begin
                        miso_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                miso_d  = 1'b0;
            end
        endcase
    end

    // State register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            tx_armed_q    <= 1'b0;
            miso_q        <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_data_q  <= '0;
            err_cnt_q     <= '0;
            holdoff_q     <= 2'd3;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            tx_armed_q    <= tx_armed_d;
            miso_q        <= miso_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_data_q  <= frame_data_d;
            err_cnt_q     <= err_cnt_d;
            holdoff_q     <= holdoff_d;
        end
    end

    assign spi_miso    = miso_q;
    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_data  = frame_data_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: directed cases plus randomized frames.
module tb_spi_frame_rx;

    localparam int FB = 16;
    localparam int AB = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          spi_clk  = 1'b0;
    logic          spi_cs   = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          rd_req;
    logic [AB-1:0] rd_addr;
    logic [FB-AB-1:0] rd_data = '0;
    logic          frame_valid;
    logic [FB-1:0] frame_data;
    logic          frame_err;
    logic [7:0]    err_cnt;

    int checks = 0;
    int errors = 0;

    // Pulse monitors.
    int n_valid = 0;
    int n_err   = 0;
    int n_rdreq = 0;
    int n_both  = 0;

    // Reference model state.
    logic [FB-1:0] exp_fd  = '0;
    int            exp_err = 0;

    always #5 clk = ~clk;

    spi_frame_rx #(
        .FRAME_BITS (FB),
        .ADDR_BITS  (AB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt)
    );

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (frame_valid && frame_err) n_both++;
        if (rd_req) n_rdreq++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One SPI bit at 10:1: data set on the rising edge, MISO read just before the fall.
    task automatic send_bit(input logic b, input bit collide, output logic miso_seen);
        spi_mosi = b;
        spi_clk  = 1'b1;
        wait_clks(5);
        miso_seen = spi_miso;
        spi_clk   = 1'b0;
        if (collide) spi_cs = 1'b1;
        else wait_clks(5);
    endtask

    // Counts clk rising edges from the CS rise until a result pulse; 0 if none.
    task automatic measure(output int lat);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_valid || frame_err) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [31:0] bits, input int nbits, input logic [7:0] rdat,
                             input bit collide);
        int v0, e0, r0, lat, eff, pos;
        bit good;
        logic m;
        logic [31:0] miso_v, exp_miso;
        v0 = n_valid; e0 = n_err; r0 = n_rdreq;
        miso_v = '0; exp_miso = '0;
        rd_data = rdat;
        spi_cs  = 1'b0;
        wait_clks(5);
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[nbits-1-i], collide && (i == nbits - 1), m);
            miso_v[i] = m;
        end
        if (!collide) begin
            wait_clks(3);
            spi_cs = 1'b1;
        end
        measure(lat);
        wait_clks(6);

        // A clock edge coinciding with the CS rise is not counted.
        eff  = collide ? nbits - 1 : nbits;
        good = (eff == FB);
        for (int i = 0; i < nbits; i++) begin
            pos = i + 1;
            if (eff >= AB && pos > AB && pos <= FB) exp_miso[i] = rdat[FB-pos];
        end
        if (good) exp_fd = bits[FB-1:0];
        else if (exp_err < 255) exp_err++;

        check_eq("valid_pulses", n_valid - v0, good);
        check_eq("err_pulses", n_err - e0, !good);
        check_eq("latency_3_or_4", (lat == 3 || lat == 4), 1);
        check_eq("frame_data", frame_data, exp_fd);
        check_eq("err_cnt", err_cnt, exp_err);
        check_eq("rd_req_pulses", n_rdreq - r0, eff >= AB);
        if (eff >= AB) check_eq("rd_addr", rd_addr, bits[nbits-1 -: 8]);
        check_eq("miso_bits", miso_v, exp_miso);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] word;
        logic m;
        int n, lat, v0, e0, r0;

        wait_clks(3);
        check_eq("rst_frame_data", frame_data, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        check_eq("rst_miso", spi_miso, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        wait_clks(5);

        // Good frame with read data.
        run_frame(32'h0705, 16, 8'hA5, 1'b0);
        // Short frame, then good frame.
        run_frame(32'h0ABC, 12, 8'h3C, 1'b0);
        run_frame(32'h0901, 16, 8'h81, 1'b0);
        // Long frame and zero-bit frame.
        run_frame(32'h000F_1234, 20, 8'h5A, 1'b0);
        run_frame(32'h0, 0, 8'h00, 1'b0);
        // CS rise together with the 16th falling edge.
        run_frame(32'h0000_BEEF, 16, 8'hC3, 1'b1);

        // Reset in the middle of a frame.
        word = 32'h0000_6D2B;
        rd_data = 8'h77;
        spi_cs = 1'b0;
        wait_clks(5);
        for (int i = 0; i < 10; i++) send_bit(word[15-i], 1'b0, m);
        rst_n = 1'b0;
        wait_clks(2);
        exp_fd = '0;
        exp_err = 0;
        check_eq("midrst_frame_data", frame_data, 0);
        check_eq("midrst_err_cnt", err_cnt, 0);
        check_eq("midrst_rd_addr", rd_addr, 0);
        check_eq("midrst_pulses", {rd_req, frame_valid, frame_err, spi_miso}, 0);
        rst_n = 1'b1;
        v0 = n_valid; e0 = n_err; r0 = n_rdreq;
        for (int i = 10; i < 16; i++) send_bit(word[15-i], 1'b0, m);
        wait_clks(3);
        spi_cs = 1'b1;
        measure(lat);
        wait_clks(6);
        check_eq("midrst_no_pulse", lat, 0);
        check_eq("midrst_valid", n_valid - v0, 0);
        check_eq("midrst_err", n_err - e0, 0);
        check_eq("midrst_rdreq", n_rdreq - r0, 0);
        run_frame(32'h0E03, 16, 8'h1E, 1'b0);

        // Randomized frames, mostly correctly sized.
        for (int k = 0; k < 40; k++) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 16;
            word = $urandom;
            run_frame(word, n, 8'($urandom), 1'b0);
        end

        // Error counter saturation.
        for (int k = 0; k < 300; k++) run_frame(32'($urandom_range(0, 1)), 1, 8'h00, 1'b0);
        check_eq("err_cnt_saturated", err_cnt, 255);
        check_eq("never_both", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
